// File: rtl/trng_word_collector.sv
// trng_word_collector: packs the accepted TRNG bit stream into WORD_W-bit
// words (first accepted bit in bit 0), runs a repetition-count health test,
// and buffers completed words in a first-word fall-through FIFO that is read
// over a valid/ready handshake.
module trng_word_collector #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RCT_LIMIT  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          random_bit,
    input  logic                          random_valid,
    output logic [WORD_W-1:0]             word_data,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          rct_fail,
    output logic                          overflow,
    input  logic                          clear_fail
);

    localparam int CW = $clog2(WORD_W);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = $clog2(RCT_LIMIT + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(WORD_W - 1);
    localparam logic [RW-1:0] RUN_LIMIT = RW'(RCT_LIMIT);
    localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

    // Registered state
    logic [CW-1:0]     cnt_r;
    logic [WORD_W-1:0] sr_r;
    logic [WORD_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr_r;
    logic [AW-1:0]     wr_ptr_r;
    logic [LW-1:0]     level_r;
    logic [RW-1:0]     run_r;
    logic              last_bit_r;
    logic              rct_fail_r;
    logic              overflow_r;
    logic [WORD_W-1:0] head_r;
    logic              valid_r;

    // Next-state / combinational signals
    logic              accept_s;
    logic [WORD_W-1:0] shifted_s;
    logic              complete_s;
    logic [RW-1:0]     run_next_s;
    logic              last_bit_next_s;
    logic              trip_s;
    logic              push_req_s;
    logic              pop_s;
    logic              full_s;
    logic              push_ok_s;
    logic              drop_s;
    logic [LW-1:0]     remain_s;
    logic [LW-1:0]     level_next_s;
    logic [AW-1:0]     rd_ptr_next_s;
    logic [AW-1:0]     wr_ptr_next_s;
    logic [WORD_W-1:0] head_next_s;
    logic [CW-1:0]     cnt_next_s;
    logic [WORD_W-1:0] sr_next_s;
    logic              rct_fail_next_s;
    logic              overflow_next_s;

    assign accept_s   = enable & random_valid & ~rct_fail_r;
    assign shifted_s  = {random_bit, sr_r[WORD_W-1:1]};
    assign complete_s = accept_s & (cnt_r == CNT_LAST);

    // Repetition-count run tracking; run_r==0 means no bit seen since reset/clear
    always_comb begin
        run_next_s      = run_r;
        last_bit_next_s = last_bit_r;
        if (clear_fail) begin
            run_next_s      = {RW{1'b0}};
            last_bit_next_s = last_bit_r;
        end else if (accept_s) begin
            last_bit_next_s = random_bit;
            if ((run_r != {RW{1'b0}}) && (random_bit == last_bit_r)) begin
                if (run_r == RUN_LIMIT) begin
                    run_next_s = run_r;
                end else begin
                    run_next_s = run_r + RW'(1);
                end
            end else begin
                run_next_s = RW'(1);
            end
        end else begin
            run_next_s      = run_r;
            last_bit_next_s = last_bit_r;
        end
    end

    // A trip discards the word completing on the same edge and flushes the FIFO
    assign trip_s     = accept_s & (run_next_s == RUN_LIMIT);
    assign push_req_s = complete_s & ~trip_s;
    assign pop_s      = valid_r & word_ready & ~rct_fail_r;
    assign full_s     = (level_r == LVL_FULL);
    assign push_ok_s  = push_req_s & (~full_s | pop_s);
    assign drop_s     = push_req_s & full_s & ~pop_s;

    // FIFO pointer/level bookkeeping and the fall-through head word
    always_comb begin
        remain_s      = level_r;
        level_next_s  = level_r;
        rd_ptr_next_s = rd_ptr_r;
        wr_ptr_next_s = wr_ptr_r;
        head_next_s   = {WORD_W{1'b0}};
        if (pop_s) begin
            remain_s      = level_r - LW'(1);
            rd_ptr_next_s = rd_ptr_r + AW'(1);
        end else begin
            remain_s      = level_r;
            rd_ptr_next_s = rd_ptr_r;
        end
        if (push_ok_s) begin
            level_next_s  = remain_s + LW'(1);
            wr_ptr_next_s = wr_ptr_r + AW'(1);
        end else begin
            level_next_s  = remain_s;
            wr_ptr_next_s = wr_ptr_r;
        end
        if (trip_s) begin
            level_next_s  = {LW{1'b0}};
            rd_ptr_next_s = {AW{1'b0}};
            wr_ptr_next_s = {AW{1'b0}};
            head_next_s   = {WORD_W{1'b0}};
        end else if (level_next_s == {LW{1'b0}}) begin
            head_next_s = {WORD_W{1'b0}};
        end else if (remain_s == {LW{1'b0}}) begin
            // FIFO empties this edge except for the word being pushed
            head_next_s = shifted_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Bit packing; disable, trip and clear all abandon the partial word
    always_comb begin
        cnt_next_s = cnt_r;
        sr_next_s  = sr_r;
        if (~enable | trip_s | clear_fail) begin
            cnt_next_s = {CW{1'b0}};
            sr_next_s  = {WORD_W{1'b0}};
        end else if (accept_s) begin
            sr_next_s = shifted_s;
            if (complete_s) begin
                cnt_next_s = {CW{1'b0}};
            end else begin
                cnt_next_s = cnt_r + CW'(1);
            end
        end else begin
            cnt_next_s = cnt_r;
            sr_next_s  = sr_r;
        end
    end

    // Sticky flags; a new overflow event wins over a coincident clear
    always_comb begin
        rct_fail_next_s = rct_fail_r;
        overflow_next_s = overflow_r;
        if (trip_s) begin
            rct_fail_next_s = 1'b1;
        end else if (clear_fail) begin
            rct_fail_next_s = 1'b0;
        end else begin
            rct_fail_next_s = rct_fail_r;
        end
        if (drop_s) begin
            overflow_next_s = 1'b1;
        end else if (clear_fail) begin
            overflow_next_s = 1'b0;
        end else begin
            overflow_next_s = overflow_r;
        end
    end

    // Control, packing and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= {CW{1'b0}};
            sr_r       <= {WORD_W{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            level_r    <= {LW{1'b0}};
            run_r      <= {RW{1'b0}};
            last_bit_r <= 1'b0;
            rct_fail_r <= 1'b0;
            overflow_r <= 1'b0;
            head_r     <= {WORD_W{1'b0}};
            valid_r    <= 1'b0;
        end else begin
            cnt_r      <= cnt_next_s;
            sr_r       <= sr_next_s;
            rd_ptr_r   <= rd_ptr_next_s;
            wr_ptr_r   <= wr_ptr_next_s;
            level_r    <= level_next_s;
            run_r      <= run_next_s;
            last_bit_r <= last_bit_next_s;
            rct_fail_r <= rct_fail_next_s;
            overflow_r <= overflow_next_s;
            head_r     <= head_next_s;
            valid_r    <= (level_next_s != {LW{1'b0}});
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {WORD_W{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= shifted_s;
        end
    end

    assign word_data  = head_r;
    assign word_valid = valid_r;
    assign fifo_level = level_r;
    assign rct_fail   = rct_fail_r;
    assign overflow   = overflow_r;

endmodule
